// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the UART TX arbitration blocks
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_e;
  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;
  localparam int GID_W = 4;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: rotate-priority picker, first asserted request after rr_ptr_i (modulo N_REQ)
module uart_rr_pick import uart_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GID_W-1:0] rr_ptr_i,
  output logic             any_o,
  output logic [GID_W-1:0] idx_o
);
  logic [15:0] req_pad;
  logic        found;
  assign req_pad = 16'(req_i);
  assign any_o   = |req_i;
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req_pad[4'((int'(rr_ptr_i) + k) % N_REQ)]) begin
        found = 1'b1;
        idx_o = GID_W'((int'(rr_ptr_i) + k) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one TX FIFO write port,
// with optional channel header, length cap and inactivity timeout.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int         N_REQ     = 4,
  parameter int         HEADER_EN = 1,
  parameter logic [7:0] HDR_BASE  = HDR_BASE_DEF,
  parameter int         MAX_LEN   = 64,
  parameter int         TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         fifo_data,
  output logic               fifo_write,
  input  logic               fifo_full,
  output logic [GID_W-1:0]   grant_id,
  output logic               busy,
  output logic               len_err,
  output logic               timeout_err
);
  localparam int IW = $clog2(TIMEOUT + 1);
  state_e           state_q, state_d;
  logic [GID_W-1:0] rr_q, rr_d, gid_q, gid_d, pick_idx;
  logic [7:0]       cnt_q, cnt_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             len_err_q, len_err_d, to_err_q, to_err_d;
  logic             pick_any, g_valid, g_last, xfer;
  logic [15:0]      valid_pad, last_pad, ready_pad;
  logic [127:0]     data_pad;
  assign valid_pad = 16'(req_valid);
  assign last_pad  = 16'(req_last);
  assign data_pad  = 128'(req_data);
  assign g_valid   = valid_pad[gid_q];
  assign g_last    = last_pad[gid_q];
  assign xfer      = state_q == DATA && g_valid && !fifo_full;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i    (req_valid),
    .rr_ptr_i (rr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= GID_W'(N_REQ - 1);
      gid_q     <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      len_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gid_q     <= gid_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      len_err_q <= len_err_d;
      to_err_q  <= to_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    len_err_d = 1'b0;
    to_err_d  = 1'b0;
    if (state_q == IDLE && pick_any) begin
      gid_d   = pick_idx;
      cnt_d   = '0;
      idle_d  = '0;
      state_d = (HEADER_EN != 0) ? HDR : DATA;
    end
    if (state_q == HDR && !fifo_full) state_d = DATA;
    if (xfer) begin
      cnt_d  = cnt_q + 8'd1;
      idle_d = '0;
      // last wins over the length cap when both land on the same byte
      if (g_last || cnt_q == 8'(MAX_LEN - 1)) begin
        state_d   = IDLE;
        rr_d      = gid_q;
        len_err_d = !g_last;
      end
    end
    if (state_q == DATA && !g_valid) begin
      if (idle_q == IW'(TIMEOUT - 1)) begin
        state_d  = IDLE;
        rr_d     = gid_q;
        to_err_d = 1'b1;
      end else idle_d = idle_q + IW'(1);
    end
  end

  always_comb begin
    ready_pad  = (state_q == DATA && !fifo_full) ? 16'(1) << gid_q : '0;
    fifo_write = (state_q == HDR && !fifo_full) || xfer;
    fifo_data  = (state_q == HDR) ? (HDR_BASE | {4'b0, gid_q}) : data_pad[{gid_q, 3'b0} +: 8];
  end

  assign req_ready   = ready_pad[N_REQ-1:0];
  assign grant_id    = gid_q;
  assign busy        = state_q != IDLE;
  assign len_err     = len_err_q;
  assign timeout_err = to_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a FIFO-byte scoreboard checked by a separate monitor
module tb_uart_tx_arbiter;
  logic        clk = 1'b0, reset;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0]  fifo_data;
  logic        fifo_write, fifo_full, busy, len_err, timeout_err;
  logic [3:0]  grant_id;
  logic [8:0]  src[4][$];
  logic [7:0]  exp_q[$];
  int          wr_cyc[$];
  int          checks = 0, fails = 0, cyc = 0, nwr = 0, nlen = 0, nto = 0, len_cyc = 0, to_cyc = 0;

  uart_tx_arbiter #(.N_REQ(4), .HEADER_EN(1), .HDR_BASE(8'hA0), .MAX_LEN(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_data(fifo_data), .fifo_write(fifo_write), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy), .len_err(len_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int i, input logic last, input logic [7:0] d);
    src[i].push_back({last, d});
  endtask

  task automatic ex(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_wr(input string name, input int target, input int budget);
    int n = 0;
    while (nwr < target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(nwr >= target), 1);
  endtask

  // requester model: pops a byte once it was accepted, holds data/last otherwise
  initial begin
    logic [3:0] fire;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && src[i].size() > 0) void'(src[i].pop_front());
        req_valid[i]        = src[i].size() > 0;
        req_data[8*i +: 8]  = src[i].size() > 0 ? src[i][0][7:0] : 8'h00;
        req_last[i]         = src[i].size() > 0 && src[i][0][8];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (len_err) begin nlen++; len_cyc = cyc; end
        if (timeout_err) begin nto++; to_cyc = cyc; end
        if (fifo_write) begin
          nwr++;
          wr_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_write actual=%0h required=none", fifo_data);
          end else check("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int l0, t0;
    reset = 1'b1;
    fifo_full = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_len_err", 32'(len_err), 0);
    check("rst_to_err", 32'(timeout_err), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_write", 32'(fifo_write), 0);
    reset = 1'b0;
    tick(2);
    // single message with header, back-to-back writes
    wr_cyc.delete();
    push(0, 0, 8'h11); push(0, 0, 8'h22); push(0, 1, 8'h33);
    ex(8'hA0); ex(8'h11); ex(8'h22); ex(8'h33);
    wait_drain("t1_drain", 50);
    check("t1_span", wr_cyc.size() == 4 ? 32'(wr_cyc[3] - wr_cyc[0]) : 32'hFFFF, 3);
    check("t1_gid", 32'(grant_id), 0);
    check("t1_busy", 32'(busy), 0);
    // round robin between requesters 1 and 2
    push(1, 1, 8'h51); push(1, 1, 8'h52);
    push(2, 1, 8'h61); push(2, 1, 8'h62);
    ex(8'hA1); ex(8'h51); ex(8'hA2); ex(8'h61); ex(8'hA1); ex(8'h52); ex(8'hA2); ex(8'h62);
    wait_drain("t2_drain", 60);
    check("t2_gid", 32'(grant_id), 2);
    // backpressure mid-payload; last on byte MAX_LEN must not raise len_err
    l0 = nlen; t0 = nto;
    push(0, 0, 8'h10); push(0, 0, 8'h20); push(0, 0, 8'h30); push(0, 1, 8'h40);
    ex(8'hA0); ex(8'h10); ex(8'h20); ex(8'h30); ex(8'h40);
    wait_wr("t3_wr", nwr + 2, 50);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_full_write", 32'(fifo_write), 0);
      check("t3_full_ready", 32'(req_ready), 0);
      tick(1);
    end
    fifo_full = 1'b0;
    wait_drain("t3_drain", 50);
    check("t3_to_err", 32'(nto - t0), 0);
    check("t3_len_err", 32'(nlen - l0), 0);
    // length truncation at MAX_LEN=4, remainder after another grant
    l0 = nlen;
    wr_cyc.delete();
    for (int b = 1; b <= 6; b++) push(3, b == 6, 8'(b));
    push(0, 1, 8'h81);
    ex(8'hA3); ex(8'h01); ex(8'h02); ex(8'h03); ex(8'h04);
    ex(8'hA0); ex(8'h81); ex(8'hA3); ex(8'h05); ex(8'h06);
    wait_drain("t4_drain", 80);
    check("t4_len_count", 32'(nlen - l0), 1);
    check("t4_len_time", wr_cyc.size() >= 5 ? 32'(len_cyc - wr_cyc[4]) : 32'hFFFF, 1);
    // timeout: 16 idle DATA cycles, registered pulse seen one sample later
    t0 = nto;
    wr_cyc.delete();
    push(2, 0, 8'h91);
    push(3, 1, 8'hB1);
    ex(8'hA2); ex(8'h91); ex(8'hA3); ex(8'hB1);
    wait_drain("t5_drain", 100);
    check("t5_to_count", 32'(nto - t0), 1);
    check("t5_to_time", wr_cyc.size() >= 2 ? 32'(to_cyc - wr_cyc[1]) : 32'hFFFF, 17);
    check("t5_gid", 32'(grant_id), 3);
    // asynchronous reset on requester 1's second byte
    push(1, 0, 8'hC1); push(1, 0, 8'hC2); push(1, 1, 8'hC3);
    ex(8'hA1); ex(8'hC1);
    wait_wr("t6_wr", nwr + 2, 50);
    check("t6_pre_write", 32'(fifo_write), 1);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) src[i].delete();
    #1;
    check("t6_rst_write", 32'(fifo_write), 0);
    check("t6_rst_ready", 32'(req_ready), 0);
    check("t6_rst_busy", 32'(busy), 0);
    tick(2);
    check("t6_rst_gid", 32'(grant_id), 0);
    reset = 1'b0;
    tick(1);
    push(0, 1, 8'hD0); push(1, 1, 8'hD1);
    ex(8'hA0); ex(8'hD0); ex(8'hA1); ex(8'hD1);
    wait_drain("t6_drain", 50);
    check("t6_gid", 32'(grant_id), 1);
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
